// File: rtl/sigmoid_backprop_pkg.sv
// sigmoid_backprop_pkg
//   Shared fixed-point definitions for the sigmoid forward/backward blocks:
//   word geometry (signed Q7.24), fixed-point constants, the sequencing FSM
//   state type and a helper that clamps a value into the sigmoid output range.
//   No ports.
package sigmoid_backprop_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned FRAC  = 24;

    localparam logic signed [WIDTH-1:0] FXP_ONE  = WIDTH'(1) << FRAC;
    localparam logic signed [WIDTH-1:0] FXP_HALF = WIDTH'(1) << (FRAC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        DONE = 2'd3
    } state_e;

    // Clamp to [0, 1.0], the legal range of a sigmoid output.
    function automatic logic signed [WIDTH-1:0] clamp_unit(input logic signed [WIDTH-1:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > FXP_ONE) begin
            return FXP_ONE;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/sigmoid_backprop_if.sv
// sigmoid_backprop_if
//   Streaming bus of the sigmoid backward unit.
//   Input side : in_valid, in_ready, y (sigmoid output), grad_y (dL/dy)
//   Output side: out_valid, out_ready, grad_x (dL/dx)
//   modport master : gradient source / sink side (drives inputs, out_ready)
//   modport slave  : the backward unit itself
interface sigmoid_backprop_if;
    import sigmoid_backprop_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] grad_y;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] grad_x;

    modport master (
        output in_valid, y, grad_y, out_ready,
        input  in_ready, out_valid, grad_x
    );

    modport slave (
        input  in_valid, y, grad_y, out_ready,
        output in_ready, out_valid, grad_x
    );

endinterface

// File: rtl/sigmoid_backprop_fx_mult.sv
// fx_mult
//   Combinational signed Q7.24 multiply: full-width product, round half up,
//   arithmetic shift right by FRAC, low WIDTH bits kept (wraps on overflow).
//   Ports:
//     a_i   in  WIDTH  multiplicand, Q7.24
//     b_i   in  WIDTH  multiplier, Q7.24
//     p_o   out WIDTH  rounded product, Q7.24
module fx_mult
    import sigmoid_backprop_pkg::*;
(
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] p_o
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] rnd;

    always_comb begin
        prod = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
        // FXP_HALF is exactly one half-LSB of the result scale.
        rnd  = prod + (2*WIDTH)'(FXP_HALF);
        p_o  = WIDTH'(rnd >>> FRAC);
    end

endmodule

// File: rtl/sigmoid_backprop.sv
// sigmoid_backprop
//   Backward pass of the sigmoid activation: grad_x = grad_y * y * (1 - y),
//   signed Q7.24. A single fx_mult is shared over two steps sequenced by a
//   small FSM (IDLE -> MUL1 -> MUL2 -> DONE). Handshake to first out_valid is
//   three cycles; peak rate is one element every four cycles.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   synchronous active-low reset
//     bus    slave modport of sigmoid_backprop_if (valid/ready in and out)
//   Build option:
//     SIGMOID_BP_CLAMP_EN  clamp y to [0, 1.0] when latched; otherwise raw y
//                          is used and out-of-range results wrap.
module sigmoid_backprop
    import sigmoid_backprop_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    sigmoid_backprop_if.slave     bus
);

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] g_q, g_d;
    logic signed [WIDTH-1:0] p_q, p_d;
    logic signed [WIDTH-1:0] grad_x_q, grad_x_d;

    logic signed [WIDTH-1:0] y_in;
    logic signed [WIDTH-1:0] one_minus_y;
    logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;

`ifdef SIGMOID_BP_CLAMP_EN
    assign y_in = clamp_unit(bus.y);
`else
    assign y_in = bus.y;
`endif

    // Wraps in WIDTH bits when y is out of range.
    assign one_minus_y = FXP_ONE - y_q;

    // MUL1 forms y*(1-y); MUL2 scales that by grad_y.
    assign mul_a = (state_q == MUL2) ? p_q : y_q;
    assign mul_b = (state_q == MUL2) ? g_q : one_minus_y;

    fx_mult u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            y_q      <= '0;
            g_q      <= '0;
            p_q      <= '0;
            grad_x_q <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            g_q      <= g_d;
            p_q      <= p_d;
            grad_x_q <= grad_x_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        g_d      = g_q;
        p_d      = p_q;
        grad_x_d = grad_x_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    y_d     = y_in;
                    g_d     = bus.grad_y;
                    state_d = MUL1;
                end
            end
            MUL1: begin
                p_d     = mul_p;
                state_d = MUL2;
            end
            MUL2: begin
                grad_x_d = mul_p;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.grad_x    = grad_x_q;

endmodule

// File: tb/tb_sigmoid_backprop.sv
module tb_sigmoid_backprop;

    logic clk = 1'b0;
    logic rst_n;
    int   chk = 0;
    int   pass = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sigmoid_backprop_if bif ();

    sigmoid_backprop dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    // Reference: grad_y * y * (1 - y) with Q7.24 round-half-up products.
    function automatic logic [31:0] fxmul(input longint a, input longint b);
        longint q;
        q = (a * b + 64'sd8388608) >>> 24;
        return q[31:0];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] yraw, input logic [31:0] g);
        longint      yv;
        logic [31:0] om;
        logic [31:0] p;
        yv = longint'($signed(yraw));
`ifdef SIGMOID_BP_CLAMP_EN
        if (yv < 0) yv = 0;
        else if (yv > 64'sd16777216) yv = 64'sd16777216;
`endif
        om = 32'h0100_0000 - yv[31:0];
        p  = fxmul(yv, longint'($signed(om)));
        return fxmul(longint'($signed(p)), longint'($signed(g)));
    endfunction

    function automatic logic [31:0] rand_y();
        logic [31:0] v;
        if ($urandom_range(0, 1) == 1) v = $urandom_range(0, 32'h0100_0000);
        else v = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        rst_n        = 1'b0;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        bif.y        = '0;
        bif.grad_y   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk++; if (bif.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bif.in_ready); else pass++;
        chk++; if (bif.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bif.out_valid); else pass++;
        chk++; if (bif.grad_x !== 32'h0) $display("FAIL reset_grad_x: got %h expected 00000000", bif.grad_x); else pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ys [3];
        logic [31:0] gs [3];
        logic [31:0] ex [3];
        ys[0] = 32'h0080_0000; gs[0] = 32'h0100_0000; ex[0] = 32'h0040_0000;
        ys[1] = 32'h0040_0000; gs[1] = 32'hFE00_0000; ex[1] = 32'hFFA0_0000;
        ys[2] = 32'h0180_0000; gs[2] = 32'h0100_0000;
`ifdef SIGMOID_BP_CLAMP_EN
        ex[2] = 32'h0000_0000;
`else
        ex[2] = 32'hFF40_0000;
`endif
        for (int i = 0; i < 3; i++) begin
            int lat;
            bit seen;
            @(negedge clk);
            bif.y = ys[i]; bif.grad_y = gs[i]; bif.in_valid = 1'b1; bif.out_ready = 1'b1;
            chk++; if (bif.in_ready !== 1'b1) $display("FAIL dir%0d_in_ready: got %b expected 1", i, bif.in_ready); else pass++;
            @(posedge clk);
            @(negedge clk);
            bif.in_valid = 1'b0;
            seen = 1'b0;
            for (lat = 1; lat <= 10; lat++) begin
                if (bif.out_valid === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk++; if (!seen || lat != 3) $display("FAIL dir%0d_latency: got %0d expected 3", i, lat); else pass++;
            chk++; if (bif.grad_x !== ex[i]) $display("FAIL dir%0d_grad_x: got %h expected %h", i, bif.grad_x, ex[i]); else pass++;
            @(negedge clk);
            chk++; if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1)
                $display("FAIL dir%0d_release: got out_valid=%b in_ready=%b expected 0/1", i, bif.out_valid, bif.in_ready);
            else pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ya, ga, yb, gb, ea, eb;
        bit seen;
        bit stable;
        ya = rand_y(); ga = $urandom; ea = model(ya, ga);
        yb = rand_y(); gb = $urandom; eb = model(yb, gb);
        @(negedge clk);
        bif.y = ya; bif.grad_y = ga; bif.in_valid = 1'b1; bif.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bif.y = yb; bif.grad_y = gb;
        seen = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (bif.out_valid === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk++; if (!seen) $display("FAIL bp_out_valid_a: got 0 expected 1"); else pass++;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bif.grad_x !== ea || bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0) begin
                $display("FAIL bp_hold_c%0d: got grad_x=%h ov=%b ir=%b expected %h/1/0",
                         c, bif.grad_x, bif.out_valid, bif.in_ready, ea);
                stable = 1'b0;
            end
            @(negedge clk);
        end
        chk++; if (!stable) $display("FAIL bp_hold: got unstable output expected stable"); else pass++;
        bif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk++; if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1)
            $display("FAIL bp_after_hs: got ov=%b ir=%b expected 0/1", bif.out_valid, bif.in_ready);
        else pass++;
        @(posedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
        chk++; if (bif.in_ready !== 1'b0) $display("FAIL bp_b_taken: got in_ready=%b expected 0", bif.in_ready); else pass++;
        seen = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (bif.out_valid === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk++; if (!seen || bif.grad_x !== eb)
            $display("FAIL bp_result_b: got %h (valid=%b) expected %h", bif.grad_x, seen, eb);
        else pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] yv [8];
        logic [31:0] gv [8];
        logic [31:0] expq [$];
        int got;
        int last_cyc;
        for (int i = 0; i < 8; i++) begin
            yv[i] = rand_y();
            gv[i] = $urandom;
            expq.push_back(model(yv[i], gv[i]));
        end
        got = 0;
        last_cyc = 0;
        bif.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    bif.y = yv[i]; bif.grad_y = gv[i]; bif.in_valid = 1'b1;
                    for (int w = 0; w < 20 && bif.in_ready !== 1'b1; w++) @(negedge clk);
                    @(posedge clk);
                end
                @(negedge clk);
                bif.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 100 && got < 8; c++) begin
                    @(negedge clk);
                    if (bif.out_valid === 1'b1) begin
                        logic [31:0] e;
                        e = expq.pop_front();
                        chk++; if (bif.grad_x !== e) $display("FAIL b2b_data%0d: got %h expected %h", got, bif.grad_x, e); else pass++;
                        if (got > 0) begin
                            chk++; if (cyc - last_cyc != 4) $display("FAIL b2b_interval%0d: got %0d expected 4", got, cyc - last_cyc); else pass++;
                        end
                        last_cyc = cyc;
                        got++;
                    end
                end
            end
        join
        chk++; if (got != 8) $display("FAIL b2b_count: got %0d expected 8", got); else pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit spur;
        @(negedge clk);
        bif.y = 32'h0080_0000; bif.grad_y = 32'h0200_0000; bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk++; if (bif.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", bif.in_ready); else pass++;
        chk++; if (bif.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b expected 0", bif.out_valid); else pass++;
        chk++; if (bif.grad_x !== 32'h0) $display("FAIL rstmid_grad_x: got %h expected 00000000", bif.grad_x); else pass++;
        rst_n = 1'b1;
        spur = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bif.out_valid === 1'b1) spur = 1'b1;
        end
        chk++; if (spur) $display("FAIL rstmid_spurious: got out_valid=1 expected 0"); else pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
